// File: rtl/io_defs.sv
// Shared definitions for io_controller: register map, STATUS bit layout and TX FSM states.
package io_defs;

  localparam logic [6:0] REG_UART_DATA = 7'd0;
  localparam logic [6:0] REG_LEDS      = 7'd1;
  localparam logic [6:0] REG_STATUS    = 7'd2;
  localparam logic [6:0] REG_CYCLES    = 7'd3;

  localparam int unsigned STATUS_EMPTY    = 0;
  localparam int unsigned STATUS_FULL     = 1;
  localparam int unsigned STATUS_BUSY     = 2;
  localparam int unsigned STATUS_OVERFLOW = 3;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

endpackage

// File: rtl/io_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the UART transmitter.
module io_tx_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       empty,
  output logic       full
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [7:0]       mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q;
  logic [AddrW-1:0] rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/io_controller.sv
// Register-bus peripheral: LED register, cycle counter, STATUS and a FIFO-fed 8N1 UART transmitter.
module io_controller
  import io_defs::*;
#(
  parameter int unsigned CLK_DIVIDE = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        uart_tx,
  output logic [15:0] leds
);

  localparam int unsigned BaudW = $clog2(CLK_DIVIDE);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_DIVIDE - 1);

  logic [15:0]      read_value_q;
  logic [15:0]      leds_q;
  logic [15:0]      cycles_q;
  logic             overflow_q;
  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;

  logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [7:0]       fifo_data;
  logic [15:0]      status;
  logic [15:0]      read_mux;
  logic             wr_leds, wr_status, wr_cycles;

  assign fifo_push = register_write && (register_index == REG_UART_DATA);
  assign wr_leds   = register_write && (register_index == REG_LEDS);
  assign wr_status = register_write && (register_index == REG_STATUS);
  assign wr_cycles = register_write && (register_index == REG_CYCLES);

  io_tx_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .push_data(register_write_value[7:0]),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    status                  = '0;
    status[STATUS_EMPTY]    = fifo_empty;
    status[STATUS_FULL]     = fifo_full;
    status[STATUS_BUSY]     = (state_q != TxIdle);
    status[STATUS_OVERFLOW] = overflow_q;
  end

  always_comb begin
    read_mux = '0;
    case (register_index)
      REG_LEDS:   read_mux = leds_q;
      REG_STATUS: read_mux = status;
      REG_CYCLES: read_mux = cycles_q;
      default:    read_mux = '0;
    endcase
  end

  // Reads sample pre-edge state, so a same-cycle write is not yet visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_value_q <= '0;
      leds_q       <= '0;
      cycles_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (register_read) read_value_q <= read_mux;
      if (wr_leds)       leds_q       <= register_write_value;
      cycles_q <= wr_cycles ? register_write_value : cycles_q + 16'd1;
      if (wr_status && register_write_value[STATUS_OVERFLOW]) begin
        overflow_q <= 1'b0;
      end else if (fifo_push && fifo_full && !fifo_pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TxIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BaudW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      TxIdle: begin
        baud_d = '0;
        if (!fifo_empty) begin
          state_d  = TxStart;
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
        end
      end
      TxStart: begin
        if (baud_q == BaudLast) begin
          state_d = TxData;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      TxData: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = TxStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      TxStop: begin
        if (baud_q == BaudLast) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data waits.
          if (!fifo_empty) begin
            state_d  = TxStart;
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
          end else begin
            state_d = TxIdle;
          end
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  always_comb begin
    unique case (state_q)
      TxStart: uart_tx = 1'b0;
      TxData:  uart_tx = shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  assign register_read_value = read_value_q;
  assign leds                = leds_q;

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller: vector table, directed UART/FIFO sequences, random traffic.
module tb_io_controller;

  localparam int CD       = 4;
  localparam int Depth    = 8;
  localparam int FrameLen = 10 * CD;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  register_index = '0;
  logic        register_read = 1'b0;
  logic        register_write = 1'b0;
  logic [15:0] register_write_value = '0;
  logic [15:0] register_read_value;
  logic        uart_tx;
  logic [15:0] leds;

  io_controller #(
    .CLK_DIVIDE(CD),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .register_index      (register_index),
    .register_read       (register_read),
    .register_write      (register_write),
    .register_write_value(register_write_value),
    .register_read_value (register_read_value),
    .uart_tx             (uart_tx),
    .leds                (leds)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: register file plus a serial-line timeline driven by a byte queue.
  logic [15:0] m_leds = '0;
  logic [15:0] m_cycles = '0;
  logic [15:0] m_rdval = '0;
  bit          m_ovf = 1'b0;
  logic [7:0]  m_q[$];
  int          m_pos = -1;
  logic [7:0]  m_byte = '0;

  function automatic logic [15:0] m_status();
    return {12'd0, m_ovf, (m_pos >= 0), (m_q.size() == Depth), (m_q.size() == 0)};
  endfunction

  function automatic logic m_tx();
    int slot;
    if (m_pos < 0) return 1'b1;
    slot = m_pos / CD;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_byte[3'(slot - 1)];
  endfunction

  task automatic model_step();
    int          pre;
    bit          pop;
    logic [15:0] st;
    st = m_status();
    if (register_read) begin
      case (register_index)
        7'd1:    m_rdval = m_leds;
        7'd2:    m_rdval = st;
        7'd3:    m_rdval = m_cycles;
        default: m_rdval = '0;
      endcase
    end
    pre = m_q.size();
    pop = (pre > 0) && (m_pos < 0 || m_pos == FrameLen - 1);
    if (pop) begin
      m_byte = m_q.pop_front();
      m_pos  = 0;
    end else if (m_pos == FrameLen - 1) begin
      m_pos = -1;
    end else if (m_pos >= 0) begin
      m_pos++;
    end
    if (register_write) begin
      case (register_index)
        7'd0: begin
          if (pre < Depth || pop) m_q.push_back(register_write_value[7:0]);
          else m_ovf = 1'b1;
        end
        7'd1: m_leds = register_write_value;
        7'd2: if (register_write_value[3]) m_ovf = 1'b0;
        default: ;
      endcase
    end
    m_cycles = (register_write && register_index == 7'd3) ? register_write_value
                                                          : m_cycles + 16'd1;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_leds   = '0;
      m_cycles = '0;
      m_rdval  = '0;
      m_ovf    = 1'b0;
      m_q.delete();
      m_pos    = -1;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_uart_tx", 32'(uart_tx), 32'(m_tx()));
      check("model_leds", 32'(leds), 32'(m_leds));
      check("model_read_value", 32'(register_read_value), 32'(m_rdval));
    end
  end

  task automatic bus(input logic [6:0] idx, input logic rd, input logic wr,
                     input logic [15:0] val);
    register_index       = idx;
    register_read        = rd;
    register_write       = wr;
    register_write_value = val;
    @(posedge clk);
    #1;
    register_read  = 1'b0;
    register_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [6:0]  idx;
    logic        rd;
    logic        wr;
    logic [15:0] wval;
    logic [15:0] exp_rd;
    logic [15:0] exp_leds;
  } vec_t;

  vec_t       vecs[15];
  logic [9:0] frame;
  int         busy_cnt;
  int         low_cnt;
  int         r;
  logic [6:0] ridx;

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{7'd1,   1'b0, 1'b1, 16'hA5C3, 16'h0000, 16'hA5C3};
    vecs[1]  = '{7'd1,   1'b1, 1'b0, 16'h0000, 16'hA5C3, 16'hA5C3};
    vecs[2]  = '{7'd1,   1'b1, 1'b1, 16'h1234, 16'hA5C3, 16'h1234};
    vecs[3]  = '{7'd1,   1'b1, 1'b0, 16'h0000, 16'h1234, 16'h1234};
    vecs[4]  = '{7'd77,  1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234};
    vecs[5]  = '{7'd77,  1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1234};
    vecs[6]  = '{7'd1,   1'b1, 1'b0, 16'h0000, 16'h1234, 16'h1234};
    vecs[7]  = '{7'd2,   1'b1, 1'b0, 16'h0000, 16'h0001, 16'h1234};
    vecs[8]  = '{7'd2,   1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234};
    vecs[9]  = '{7'd2,   1'b1, 1'b0, 16'h0000, 16'h0001, 16'h1234};
    vecs[10] = '{7'd0,   1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1234};
    vecs[11] = '{7'd1,   1'b1, 1'b0, 16'h0000, 16'h1234, 16'h1234};
    vecs[12] = '{7'd127, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1234};
    vecs[13] = '{7'd1,   1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[14] = '{7'd2,   1'b1, 1'b0, 16'h0000, 16'h0001, 16'h0000};

    reset_n = 1'b0;
    idle(2);
    chk_en = 1'b1;
    idle(1);
    reset_n = 1'b1;
    check("reset_uart_tx", 32'(uart_tx), 32'h1);
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_read_value", 32'(register_read_value), 32'h0);

    for (int i = 0; i < 15; i++) begin
      bus(vecs[i].idx, vecs[i].rd, vecs[i].wr, vecs[i].wval);
      if (vecs[i].rd) check($sformatf("table_read[%0d]", i), 32'(register_read_value),
                            32'(vecs[i].exp_rd));
      check($sformatf("table_leds[%0d]", i), 32'(leds), 32'(vecs[i].exp_leds));
    end

    // Counter wrap: load at E, three idle clocks, read at E+4.
    bus(7'd3, 1'b0, 1'b1, 16'hFFFE);
    idle(3);
    bus(7'd3, 1'b1, 1'b0, 16'h0000);
    check("cycles_wrap", 32'(register_read_value), 32'h0001);

    // Single 0x48 frame, STATUS polled every cycle.
    frame = {1'b1, 8'h48, 1'b0};
    bus(7'd0, 1'b0, 1'b1, 16'h0048);
    check("tx_idle_on_push_edge", 32'(uart_tx), 32'h1);
    busy_cnt = 0;
    for (int k = 0; k < 44; k++) begin
      bus(7'd2, 1'b1, 1'b0, 16'h0000);
      if (k < 40) check("frame_bit", 32'(uart_tx), 32'(frame[4'(k / 4)]));
      else check("frame_after_stop", 32'(uart_tx), 32'h1);
      if (register_read_value[2]) busy_cnt++;
    end
    check("frame_busy_cycles", 32'(busy_cnt), 32'd40);

    // Ten pushes: one popped, eight stored, one dropped.
    for (int i = 0; i < 10; i++) bus(7'd0, 1'b0, 1'b1, 16'(8'h30 + i));
    bus(7'd2, 1'b1, 1'b0, 16'h0000);
    check("status_full_overflow", 32'(register_read_value), 32'h000E);
    bus(7'd2, 1'b0, 1'b1, 16'h0008);
    bus(7'd2, 1'b1, 1'b0, 16'h0000);
    check("status_overflow_cleared", 32'(register_read_value), 32'h0006);
    // Nine gapless frames from E+1 to E+361; polling reads land on E+13..E+412.
    busy_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      bus(7'd2, 1'b1, 1'b0, 16'h0000);
      if (register_read_value[2]) busy_cnt++;
    end
    check("back_to_back_busy", 32'(busy_cnt), 32'd349);

    // Push at full landing on the STOP->START pop edge (E+41).
    for (int i = 0; i < 9; i++) bus(7'd0, 1'b0, 1'b1, 16'(8'h50 + i));
    idle(32);
    bus(7'd0, 1'b0, 1'b1, 16'h005F);
    bus(7'd2, 1'b1, 1'b0, 16'h0000);
    check("full_push_pop_status", 32'(register_read_value), 32'h0006);
    idle(9 * FrameLen + 10);

    // Reset mid-frame.
    bus(7'd1, 1'b0, 1'b1, 16'hBEEF);
    bus(7'd0, 1'b0, 1'b1, 16'h00AA);
    bus(7'd0, 1'b0, 1'b1, 16'h0055);
    bus(7'd0, 1'b0, 1'b1, 16'h0011);
    idle(2);
    check("pre_reset_start_bit", 32'(uart_tx), 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_uart_tx", 32'(uart_tx), 32'h1);
    check("async_reset_leds", 32'(leds), 32'h0);
    idle(2);
    reset_n = 1'b1;
    bus(7'd2, 1'b1, 1'b0, 16'h0000);
    check("post_reset_status", 32'(register_read_value), 32'h0001);
    low_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      idle(1);
      if (!uart_tx) low_cnt++;
    end
    check("post_reset_fifo_discarded", 32'(low_cnt), 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35) ridx = 7'd0;
      else if (r < 50) ridx = 7'd1;
      else if (r < 65) ridx = 7'd2;
      else if (r < 75) ridx = 7'd3;
      else ridx = 7'($urandom_range(4, 127));
      bus(ridx, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 16'($urandom));
    end
    idle(FrameLen * (Depth + 2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
